// File: rtl/cmd_uart_frame_rx.sv
// cmd_uart_frame_rx: UART (8N1) command receiver. Parses frames A5/SEL/DATA/CHK
// (CHK = SEL ^ DATA) and drives the sel/data/en parameter-latch bus with one
// setup (en=0) then commit (en=1) sequence per accepted frame.
module cmd_uart_frame_rx #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD      = 115_200,
  parameter int SETUP_CYC = 2,
  parameter int EN_HOLD   = 4,
  parameter int TO_CYC    = 50_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic [2:0] sel,
  output logic [7:0] data,
  output logic       en,
  output logic       frame_ok,
  output logic [7:0] err_cnt
);

  localparam int CPB = CLK_FREQ / BAUD;
  localparam int CW  = $clog2(CPB + 1);
  localparam logic [CW-1:0] CPB_M1  = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CPB / 2 - 1);
  localparam int TW  = $clog2(TO_CYC + 1);
  localparam logic [TW-1:0] TO_M1 = TW'(TO_CYC - 1);
  localparam int PW  = $clog2(SETUP_CYC + EN_HOLD + 1);
  localparam logic [PW-1:0] SETUP_M1 = PW'(SETUP_CYC - 1);
  localparam logic [PW-1:0] HOLD_M1  = PW'(EN_HOLD - 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [2:0] {P_HDR, P_SEL, P_DATA, P_SUM, P_APPLY, P_COMMIT} p_state_t;

  // Receiver state
  logic          rx_s1_q, rx_s2_q, rx_prev_q;
  rx_state_t     rx_st_q, rx_st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          byte_valid, frame_err;

  // Parser state
  p_state_t      ps_q, ps_d;
  logic [TW-1:0] to_q, to_d;
  logic [PW-1:0] ph_q, ph_d;
  logic [7:0]    selb_q, selb_d;
  logic [7:0]    datb_q, datb_d;
  logic [7:0]    data_q, data_d;
  logic [7:0]    err_q, err_d;
  logic          err_inc, sum_ok;

  // Synchronizer, edge history and receiver control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
      rx_st_q   <= R_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
    end else begin
      rx_s1_q   <= uart_rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      rx_st_q   <= rx_st_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
    end
  end

  // Receive shift register holds only data, so it needs no reset
  always_ff @(posedge clk) begin
    sh_q <= sh_d;
  end

  // Receiver next-state: start validation at mid start bit, then one sample per bit period
  always_comb begin
    rx_st_d    = rx_st_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    sh_d       = sh_q;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    case (rx_st_q)
      R_IDLE: begin
        cnt_d = '0;
        if (rx_prev_q && !rx_s2_q) rx_st_d = R_START;
      end
      R_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          bit_d   = '0;
          rx_st_d = rx_s2_q ? R_IDLE : R_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      R_DATA: begin
        if (cnt_q == CPB_M1) begin
          cnt_d = '0;
          sh_d  = {rx_s2_q, sh_q[7:1]};
          if (bit_q == 3'd7) rx_st_d = R_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      R_STOP: begin
        if (cnt_q == CPB_M1) begin
          cnt_d   = '0;
          rx_st_d = R_IDLE;
          if (rx_s2_q) byte_valid = 1'b1;
          else         frame_err  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: rx_st_d = R_IDLE;
    endcase
  end

  // SEL must be a real target (1..6) with upper bits clear, and the checksum must match
  assign sum_ok = (sh_q == (selb_q ^ datb_q)) && (selb_q[7:3] == 5'd0) &&
                  (selb_q[2:0] != 3'd0) && (selb_q[2:0] != 3'd7);

  // Parser control registers and the bus data register
  always_ff @(posedge clk) begin
    if (rst) begin
      ps_q   <= P_HDR;
      to_q   <= '0;
      ph_q   <= '0;
      err_q  <= '0;
      data_q <= '0;
    end else begin
      ps_q   <= ps_d;
      to_q   <= to_d;
      ph_q   <= ph_d;
      err_q  <= err_d;
      data_q <= data_d;
    end
  end

  // Captured SEL/DATA bytes are qualified by the parser state, so no reset needed
  always_ff @(posedge clk) begin
    selb_q <= selb_d;
    datb_q <= datb_d;
  end

  // Parser next-state: frame assembly, inter-byte timeout, apply/commit sequencing
  always_comb begin
    ps_d    = ps_q;
    to_d    = '0;
    ph_d    = ph_q;
    selb_d  = selb_q;
    datb_d  = datb_q;
    data_d  = data_q;
    err_inc = 1'b0;
    case (ps_q)
      P_HDR: begin
        if (byte_valid && sh_q == 8'hA5) ps_d = P_SEL;
      end
      P_SEL, P_DATA, P_SUM: begin
        if (byte_valid) begin
          if (ps_q == P_SEL) begin
            selb_d = sh_q;
            ps_d   = P_DATA;
          end else if (ps_q == P_DATA) begin
            datb_d = sh_q;
            ps_d   = P_SUM;
          end else if (sum_ok) begin
            data_d = datb_q;
            ph_d   = '0;
            ps_d   = P_APPLY;
          end else begin
            err_inc = 1'b1;
            ps_d    = P_HDR;
          end
        end else if (to_q == TO_M1) begin
          err_inc = 1'b1;
          ps_d    = P_HDR;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      P_APPLY: begin
        if (ph_q == SETUP_M1) begin
          ph_d = '0;
          ps_d = P_COMMIT;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      P_COMMIT: begin
        if (ph_q == HOLD_M1) begin
          ph_d = '0;
          ps_d = P_HDR;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      default: ps_d = P_HDR;
    endcase
    // A bad stop bit abandons any frame in progress; a coincident timeout still counts once
    if (frame_err) begin
      err_inc = 1'b1;
      to_d    = '0;
      ps_d    = P_HDR;
    end
    err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
  end

  assign sel      = (ps_q == P_APPLY || ps_q == P_COMMIT) ? selb_q[2:0] : 3'd0;
  assign data     = data_q;
  assign en       = (ps_q == P_COMMIT);
  assign frame_ok = (ps_q == P_APPLY) && (ph_q == '0);
  assign err_cnt  = err_q;

endmodule

// File: tb/tb_cmd_uart_frame_rx.sv
// Testbench for cmd_uart_frame_rx: UART byte driver, frame-level reference model
// (byte buffer per frame, expected commit queue, saturating error count) and a bus monitor.
module tb_cmd_uart_frame_rx;

  localparam int CLK_FREQ = 800_000;
  localparam int BAUD     = 100_000;
  localparam int CPB      = CLK_FREQ / BAUD;
  localparam int SETUP    = 2;
  localparam int HOLD     = 4;
  localparam int TO       = 500;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       uart_rx = 1'b1;
  logic [2:0] sel;
  logic [7:0] data;
  logic       en;
  logic       frame_ok;
  logic [7:0] err_cnt;

  always #5 clk = ~clk;

  cmd_uart_frame_rx #(
    .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .SETUP_CYC(SETUP), .EN_HOLD(HOLD), .TO_CYC(TO)
  ) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx), .sel(sel), .data(data),
    .en(en), .frame_ok(frame_ok), .err_cnt(err_cnt)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Reference model
  logic [7:0]  fb[$];
  logic [10:0] exp_q[$];
  logic [10:0] obs_q[$];
  int          m_err = 0;
  int          idle_viol = 0;

  function automatic void m_err_inc();
    if (m_err < 255) m_err++;
  endfunction

  function automatic void m_byte(input logic [7:0] b, input logic stop);
    logic [7:0] s, d;
    if (!stop) begin
      m_err_inc();
      fb.delete();
      return;
    end
    if (fb.size() == 0) begin
      if (b == 8'hA5) fb.push_back(b);
      return;
    end
    fb.push_back(b);
    if (fb.size() == 4) begin
      s = fb[1];
      d = fb[2];
      if (b == (s ^ d) && s >= 8'd1 && s <= 8'd6) exp_q.push_back({s[2:0], d});
      else m_err_inc();
      fb.delete();
    end
  endfunction

  function automatic void m_timeout();
    if (fb.size() > 0) begin
      m_err_inc();
      fb.delete();
    end
  endfunction

  function automatic void m_reset();
    fb.delete();
    exp_q.delete();
    obs_q.delete();
    m_err = 0;
  endfunction

  // Stimulus helpers; inputs change 1 time unit after a rising edge
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    wait_cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      wait_cyc(CPB);
    end
    uart_rx = stop;
    wait_cyc(CPB);
    if (!stop) begin
      uart_rx = 1'b1;
      wait_cyc(CPB);
    end
  endtask

  task automatic tx(input logic [7:0] b, input logic stop);
    send_byte(b, stop);
    m_byte(b, stop);
    wait_cyc($urandom_range(1, 3));
  endtask

  task automatic tx_frame(input logic [7:0] s, input logic [7:0] d, input logic [7:0] c);
    tx(8'hA5, 1'b1);
    tx(s, 1'b1);
    tx(d, 1'b1);
    tx(c, 1'b1);
  endtask

  task automatic settle_compare(input string tag);
    int n;
    wait_cyc(40);
    check({tag, "_n_commits"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_commit"}, 32'(obs_q[i]), 32'(exp_q[i]));
    check({tag, "_err_cnt"}, 32'(err_cnt), m_err);
    exp_q.delete();
    obs_q.delete();
  endtask

  // Bus monitor: validates each setup/commit window and records the committed pair
  initial begin : mon
    logic [2:0] ms;
    logic [7:0] md;
    bit         ok, ab;
    forever begin
      @(negedge clk);
      if (!rst && frame_ok === 1'b1) begin
        ms = sel;
        md = data;
        ok = 1'b1;
        ab = 1'b0;
        for (int i = 0; i < SETUP + HOLD; i++) begin
          if (i > 0) @(negedge clk);
          if (rst) begin
            ab = 1'b1;
            break;
          end
          if (en !== (i >= SETUP) || sel !== ms || data !== md) ok = 1'b0;
          if (i > 0 && frame_ok !== 1'b0) ok = 1'b0;
        end
        if (!ab) begin
          @(negedge clk);
          if (rst) ab = 1'b1;
          else if (sel !== 3'd0 || en !== 1'b0 || data !== md) ok = 1'b0;
        end
        if (!ab) begin
          check("commit_shape", 32'(ok), 32'd1);
          obs_q.push_back({ms, md});
        end
      end else if (!rst && (sel !== 3'd0 || en !== 1'b0)) begin
        idle_viol++;
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    logic [7:0] s8, d8, c8;
    int         k;
    bit         seen;

    // Reset values
    wait_cyc(3);
    @(negedge clk);
    check("rst_sel", 32'(sel), 0);
    check("rst_data", 32'(data), 0);
    check("rst_en", 32'(en), 0);
    check("rst_frame_ok", 32'(frame_ok), 0);
    check("rst_err_cnt", 32'(err_cnt), 0);
    wait_cyc(1);
    rst = 1'b0;
    m_reset();
    wait_cyc(5);

    // 1: good frame
    tx_frame(8'h03, 8'h05, 8'h06);
    settle_compare("t1");
    check("t1_data_hold", 32'(data), 32'h05);
    check("t1_sel_idle", 32'(sel), 0);

    // 2: bad checksum
    tx_frame(8'h01, 8'h02, 8'h00);
    settle_compare("t2");
    check("t2_err_cnt_abs", 32'(err_cnt), 1);

    // 3: framing error on SEL, then a good frame
    m_reset();
    rst = 1'b1; wait_cyc(2); rst = 1'b0; wait_cyc(2);
    tx(8'hA5, 1'b1);
    tx(8'h04, 1'b0);
    tx_frame(8'h04, 8'h07, 8'h03);
    settle_compare("t3");
    check("t3_err_cnt_abs", 32'(err_cnt), 1);

    // 4: leading junk then a good frame
    tx(8'h00, 1'b1);
    tx(8'hFF, 1'b1);
    tx_frame(8'h05, 8'h80, 8'h85);
    settle_compare("t4");

    // 5: inter-byte timeout, then a frame with SEL 7
    tx(8'hA5, 1'b1);
    tx(8'h02, 1'b1);
    uart_rx = 1'b1;
    wait_cyc(TO + 20);
    m_timeout();
    check("t5_timeout_err", 32'(err_cnt), m_err);
    tx_frame(8'h07, 8'h00, 8'h07);
    settle_compare("t5");

    // Randomized frames and faults
    for (int it = 0; it < 30; it++) begin
      k  = $urandom_range(0, 6);
      s8 = 8'($urandom_range(1, 6));
      d8 = 8'($urandom);
      case (k)
        0, 1, 2: tx_frame(s8, d8, s8 ^ d8);
        3: tx_frame(s8, d8, (s8 ^ d8) ^ (8'd1 << $urandom_range(0, 7)));
        4: begin
          case ($urandom_range(0, 2))
            0:       c8 = 8'h00;
            1:       c8 = 8'h07;
            default: c8 = 8'h80 | s8;
          endcase
          tx_frame(c8, d8, c8 ^ d8);
        end
        5: tx(8'($urandom), 1'b1);
        default: tx(8'($urandom), 1'b0);
      endcase
      if (it % 10 == 9) settle_compare("rnd");
    end
    settle_compare("rnd_end");

    // err_cnt saturation
    for (int i = 0; i < 260; i++) begin
      d8 = 8'($urandom);
      send_byte(d8, 1'b0);
      m_byte(d8, 1'b0);
    end
    settle_compare("sat");
    check("sat_err_255", 32'(err_cnt), 255);

    // 6a: reset during commit
    seen = 1'b0;
    fork
      begin
        send_byte(8'hA5, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h05, 1'b1);
        send_byte(8'h06, 1'b1);
      end
      begin
        for (int i = 0; i < 8000; i++) begin
          @(negedge clk);
          if (en === 1'b1) begin
            seen = 1'b1;
            break;
          end
        end
        check("t6_en_seen", 32'(seen), 1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t6a_en", 32'(en), 0);
        check("t6a_sel", 32'(sel), 0);
        check("t6a_data", 32'(data), 0);
        check("t6a_frame_ok", 32'(frame_ok), 0);
        check("t6a_err_cnt", 32'(err_cnt), 0);
      end
    join
    wait_cyc(2);
    m_reset();
    rst = 1'b0;
    wait_cyc(5);

    // 6b: reset in the middle of a received byte
    tx_frame(8'h01, 8'h02, 8'h00);
    settle_compare("t6pre");
    fork
      send_byte(8'h5A, 1'b1);
      begin
        wait_cyc(4 * CPB);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t6b_en", 32'(en), 0);
        check("t6b_sel", 32'(sel), 0);
        check("t6b_data", 32'(data), 0);
        check("t6b_err_cnt", 32'(err_cnt), 0);
      end
    join
    wait_cyc(2);
    m_reset();
    rst = 1'b0;
    wait_cyc(5);
    tx_frame(8'h04, 8'h07, 8'h03);
    settle_compare("t6post");

    check("sel_en_idle_zero", idle_viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
